hart_slot_sched: RTL and testbench
==================================

# hart_slot_sched

Barrel-pipeline hart scheduler for the BRISKI core. Every cycle it issues the next hart slot in strict round-robin order and drives the fetch-stage hart ID and issue-valid. It tracks a per-hart RUN/SLEEP state driven by sleep requests from writeback and external wake lines. It also carries each issued slot down a PIPE_DEPTH-deep valid/ID shift chain so that writeback knows which slot is retiring.

## Interface
- NUM_HARTS, 16, number of hardware harts; power of two, ≥2
- HART_ID_W, $clog2(NUM_HARTS), hart ID width (derived; do not override)
- PIPE_DEPTH, 4, cycles from issue to writeback slot; ≥1
- RESET_ACTIVE_MASK, all ones, per-hart RUN(1)/SLEEP(0) state loaded at reset

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- i_halt  in  1  global freeze of slot rotation
- i_sleep_valid  in  1  writeback requests that hart i_sleep_hart go to sleep
- i_sleep_hart  in  HART_ID_W  hart named by the sleep request
- i_wake  in  NUM_HARTS  per-hart wake request, sampled every cycle
- o_hart_id  out  HART_ID_W  slot issued this cycle
- o_issue_valid  out  1  slot o_hart_id carries a real instruction
- o_hart_active  out  NUM_HARTS  per-hart RUN state
- o_wb_valid  out  1  issue_valid delayed PIPE_DEPTH cycles
- o_wb_hart_id  out  HART_ID_W  hart_id delayed PIPE_DEPTH cycles

## Operation
- Slot counter `cnt`:
  - Increments by 1 each cycle and wraps NUM_HARTS-1 → 0.
  - Holds while i_halt=1.
  - o_hart_id = cnt.
- o_issue_valid = active[cnt] & ~i_halt & ~reset.
- Per-hart state machine, RUN ↔ SLEEP:
  - RUN → SLEEP on i_sleep_valid with i_sleep_hart=h, unless a wake is present or pending for h (see below).
  - SLEEP → RUN on i_wake[h]=1.
  - Sleep request to a hart already in SLEEP: no effect.
- Simultaneous i_wake[h] and a sleep request for h in the same cycle: wake wins. The hart stays or becomes RUN, and the pending bit for h is not set.
- Multiple harts may wake in the same cycle. Only one sleep request is accepted per cycle.
- Sleeping harts still own their slot. The rotation never skips a slot, which preserves barrel hazard freedom.
- Writeback chain:
  - PIPE_DEPTH stages of {valid, hart_id}, shifting every cycle, including while i_halt=1.
  - Stage 0 loads {o_issue_valid, o_hart_id}.
  - o_wb_* is the last stage.
- Reset mid-operation (synchronous):
  - cnt←0
  - active←RESET_ACTIVE_MASK
  - pending←0
  - all chain valids←0 (chain IDs also ←0)
  - In-flight slots are discarded.

## Timing
- Reset values:
  - o_hart_id=0
  - o_issue_valid=0 while reset=1
  - o_hart_active=RESET_ACTIVE_MASK
  - o_wb_valid=0
  - o_wb_hart_id=0
- First cycle after reset deasserts: hart 0 issues if RESET_ACTIVE_MASK[0].
- Sleep request at cycle t for hart h: active[h]=0 from t+1. Any slot for h at cycle ≥t+1 has o_issue_valid=0.
- Wake at cycle t: active[h]=1 from t+1.
- Issue at cycle t appears on o_wb_* at cycle t+PIPE_DEPTH.
- No combinational path from i_sleep_* or i_wake to any output. i_halt reaches o_issue_valid combinationally only.

## Configuration
- HART_SLOT_SCHED_WAKE_PENDING_EN defined:
  - i_wake[h] while h is RUN sets pending[h].
  - A later sleep request for h clears pending[h]; h stays RUN.
  - Reset clears pending.
- Undefined:
  - No pending register.
  - A wake to a RUN hart is dropped.
  - A later sleep request puts h to SLEEP normally.

## Test plan
(NUM_HARTS=4, PIPE_DEPTH=3, RESET_ACTIVE_MASK=4'b1111)
- Release reset, run 10 cycles → o_hart_id=0,1,2,3,0,1,…; o_issue_valid=1 every cycle; o_wb_valid first 1 three cycles after first issue, with o_wb_hart_id=0.
- i_sleep_valid, i_sleep_hart=2 at cycle t → o_hart_active=4'b1011 at t+1; slot 2 has issue_valid=0 while slots 0,1,3 stay valid; rotation still visits 2.
- Hart 2 asleep, i_wake=4'b0100 → active[2]=1 next cycle; next slot-2 issue_valid=1.
- Same-cycle sleep(hart 1) and i_wake[1] → hart 1 remains RUN; pending[1]=0.
- With macro: i_wake[3] while hart 3 RUN, then sleep(hart 3) 5 cycles later → hart 3 stays RUN and pending clears; a second sleep(3) → SLEEP. Without macro: the first sleep → SLEEP.
- i_halt=1 for 3 cycles at cnt=1 → o_hart_id holds 1, o_issue_valid=0, wb chain drains valids; assert reset mid-run → next cycle cnt=0, o_wb_valid=0, active=4'b1111.

Source files
------------

// File: rtl/hart_slot_sched.sv
// ---------------------------------------------------------------------------
// hart_slot_sched
//
// Barrel-pipeline hart scheduler. A slot counter walks the harts in strict
// round-robin order, one slot per cycle, and never skips a slot. A sleeping
// hart still owns its slot; only its issue-valid drops. Each issued slot is
// also carried down a PIPE_DEPTH-deep {valid, hart_id} shift chain, so that
// writeback knows which slot is retiring.
//
// Optional feature (macro HART_SLOT_SCHED_WAKE_PENDING_EN):
//   A wake that arrives while a hart is already RUN is remembered in a
//   per-hart pending bit. The next sleep request to that hart consumes the
//   pending bit, and the hart stays RUN. Without the macro, a wake to a RUN
//   hart is dropped.
//
// Parameters:
//   NUM_HARTS          number of harts (power of two, >= 2)
//   HART_ID_W          hart ID width, derived from NUM_HARTS (do not override)
//   PIPE_DEPTH         cycles from issue to writeback slot (>= 1)
//   RESET_ACTIVE_MASK  per-hart RUN(1)/SLEEP(0) state loaded at reset
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   i_halt         freezes slot rotation and suppresses issue
//   i_sleep_valid  writeback asks hart i_sleep_hart to sleep
//   i_sleep_hart   hart named by the sleep request
//   i_wake         per-hart wake request
//   o_hart_id      slot issued this cycle
//   o_issue_valid  slot o_hart_id carries a real instruction
//   o_hart_active  per-hart RUN state (1 = RUN); also the FSM state view
//   o_wb_valid     o_issue_valid delayed by PIPE_DEPTH cycles
//   o_wb_hart_id   o_hart_id delayed by PIPE_DEPTH cycles
//
// Handshake: there is no back-pressure. o_issue_valid qualifies o_hart_id in
// the same cycle. o_wb_valid qualifies o_wb_hart_id in the same cycle. The
// sleep request is a single-cycle strobe, and i_wake is a level that is
// sampled on every edge.
// ---------------------------------------------------------------------------
module hart_slot_sched #(
    parameter int                   NUM_HARTS         = 16,
    parameter int                   HART_ID_W         = $clog2(NUM_HARTS),
    parameter int                   PIPE_DEPTH        = 4,
    parameter logic [NUM_HARTS-1:0] RESET_ACTIVE_MASK = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_halt,
    input  logic                 i_sleep_valid,
    input  logic [HART_ID_W-1:0] i_sleep_hart,
    input  logic [NUM_HARTS-1:0] i_wake,
    output logic [HART_ID_W-1:0] o_hart_id,
    output logic                 o_issue_valid,
    output logic [NUM_HARTS-1:0] o_hart_active,
    output logic                 o_wb_valid,
    output logic [HART_ID_W-1:0] o_wb_hart_id
);

    typedef enum logic {
        HART_SLEEP = 1'b0,
        HART_RUN   = 1'b1
    } hart_state_e;

    localparam logic [HART_ID_W-1:0] LAST_SLOT = HART_ID_W'(NUM_HARTS - 1);

    logic [HART_ID_W-1:0]  cnt_q;
    logic [HART_ID_W-1:0]  cnt_d;
    hart_state_e           state_q [NUM_HARTS];
    hart_state_e           state_d [NUM_HARTS];
    logic [NUM_HARTS-1:0]  active;
    logic [NUM_HARTS-1:0]  sleep_sel;
    logic [PIPE_DEPTH-1:0] wb_v_q;
    logic [HART_ID_W-1:0]  wb_id_q [PIPE_DEPTH];
    logic                  issue_valid;
`ifdef HART_SLOT_SCHED_WAKE_PENDING_EN
    logic [NUM_HARTS-1:0]  pending_q;
    logic [NUM_HARTS-1:0]  pending_d;
`endif

    // One-hot decode of the single sleep request that may arrive this cycle.
    always_comb begin
        sleep_sel = '0;
        if (i_sleep_valid) begin
            sleep_sel[i_sleep_hart] = 1'b1;
        end
    end

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            active[h] = (state_q[h] == HART_RUN);
        end
    end

    // The rotation never skips a slot. Only i_halt stops it.
    always_comb begin
        cnt_d = cnt_q;
        if (!i_halt) begin
            cnt_d = (cnt_q == LAST_SLOT) ? '0 : cnt_q + HART_ID_W'(1);
        end
    end

    // Per-hart RUN/SLEEP next state. A wake in the same cycle as a sleep
    // request for the same hart cancels the sleep, and it does not arm
    // pending, because the wake has already been used up by that cancel.
    always_comb begin
`ifdef HART_SLOT_SCHED_WAKE_PENDING_EN
        pending_d = pending_q;
`endif
        for (int h = 0; h < NUM_HARTS; h++) begin
            state_d[h] = state_q[h];
            case (state_q[h])
                HART_RUN: begin
                    if (sleep_sel[h] && !i_wake[h]) begin
`ifdef HART_SLOT_SCHED_WAKE_PENDING_EN
                        if (pending_q[h]) begin
                            pending_d[h] = 1'b0;
                        end else begin
                            state_d[h] = HART_SLEEP;
                        end
`else
                        state_d[h] = HART_SLEEP;
`endif
                    end
`ifdef HART_SLOT_SCHED_WAKE_PENDING_EN
                    else if (i_wake[h] && !sleep_sel[h]) begin
                        pending_d[h] = 1'b1;
                    end
`endif
                end
                HART_SLEEP: begin
                    if (i_wake[h]) begin
                        state_d[h] = HART_RUN;
                    end
                end
                default: state_d[h] = HART_RUN;
            endcase
        end
    end

    // Reset gates issue in the same cycle, so that no slot leaves while the
    // chain is being cleared.
    assign issue_valid = active[cnt_q] & ~i_halt & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                state_q[h] <= RESET_ACTIVE_MASK[h] ? HART_RUN : HART_SLEEP;
            end
`ifdef HART_SLOT_SCHED_WAKE_PENDING_EN
            pending_q <= '0;
`endif
            wb_v_q <= '0;
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                wb_id_q[s] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int h = 0; h < NUM_HARTS; h++) begin
                state_q[h] <= state_d[h];
            end
`ifdef HART_SLOT_SCHED_WAKE_PENDING_EN
            pending_q <= pending_d;
`endif
            // The chain keeps shifting during halt, so in-flight slots drain.
            wb_v_q[0]  <= issue_valid;
            wb_id_q[0] <= cnt_q;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                wb_v_q[s]  <= wb_v_q[s-1];
                wb_id_q[s] <= wb_id_q[s-1];
            end
        end
    end

    assign o_hart_id     = cnt_q;
    assign o_issue_valid = issue_valid;
    assign o_hart_active = active;
    assign o_wb_valid    = wb_v_q[PIPE_DEPTH-1];
    assign o_wb_hart_id  = wb_id_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_hart_slot_sched.sv
// ---------------------------------------------------------------------------
// tb_hart_slot_sched
//
// Bench for hart_slot_sched with NUM_HARTS=4, PIPE_DEPTH=3 and an all-RUN
// reset mask. A behavioural model predicts each cycle's outputs. Every
// predicted issue is pushed onto exp_q, and the entry is popped when the DUT
// presents it on the writeback port.
// ---------------------------------------------------------------------------
module tb_hart_slot_sched;

    localparam int         NH   = 4;
    localparam int         IDW  = 2;
    localparam int         D    = 3;
    localparam logic [3:0] MASK = 4'b1111;

    // Clock and reset
    logic            clk = 1'b0;
    logic            reset;
    logic            i_halt;
    logic            i_sleep_valid;
    logic [IDW-1:0]  i_sleep_hart;
    logic [NH-1:0]   i_wake;
    logic [IDW-1:0]  o_hart_id;
    logic            o_issue_valid;
    logic [NH-1:0]   o_hart_active;
    logic            o_wb_valid;
    logic [IDW-1:0]  o_wb_hart_id;

    always #5 clk = ~clk;

    hart_slot_sched #(
        .NUM_HARTS        (NH),
        .PIPE_DEPTH       (D),
        .RESET_ACTIVE_MASK(MASK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_halt       (i_halt),
        .i_sleep_valid(i_sleep_valid),
        .i_sleep_hart (i_sleep_hart),
        .i_wake       (i_wake),
        .o_hart_id    (o_hart_id),
        .o_issue_valid(o_issue_valid),
        .o_hart_active(o_hart_active),
        .o_wb_valid   (o_wb_valid),
        .o_wb_hart_id (o_wb_hart_id)
    );

    // Scoreboard and model state
    logic [IDW-1:0] exp_q[$];
    logic [IDW-1:0] m_cnt    = '0;
    logic [NH-1:0]  m_active = MASK;
    logic [NH-1:0]  m_pend   = '0;
    logic [D-1:0]   m_wbv    = '0;
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Driver: one clock cycle. Called at posedge+1. It drives the inputs,
    // checks the outputs at the negedge, advances the model, and then
    // returns at posedge+1.
    task automatic cycle(input logic halt, input logic sv, input logic [IDW-1:0] sh,
                         input logic [NH-1:0] wk, input logic rst);
        logic           exp_iv;
        logic [IDW-1:0] e;
        logic [NH-1:0]  n_active;
        logic [NH-1:0]  n_pend;
        reset         = rst;
        i_halt        = halt;
        i_sleep_valid = sv;
        i_sleep_hart  = sh;
        i_wake        = wk;
        @(negedge clk);
        exp_iv = m_active[m_cnt] & ~halt & ~rst;
        check("hart_id", 32'(o_hart_id), 32'(m_cnt));
        check("issue_valid", 32'(o_issue_valid), 32'(exp_iv));
        check("hart_active", 32'(o_hart_active), 32'(m_active));
        check("wb_valid", 32'(o_wb_valid), 32'(m_wbv[D-1]));
        if (o_wb_valid) begin
            check("wb_q_empty", 32'(exp_q.size() == 0), 32'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wb_hart_id", 32'(o_wb_hart_id), 32'(e));
            end
        end
        // Model update for the coming edge.
        m_wbv = {m_wbv[D-2:0], exp_iv};
        if (exp_iv) exp_q.push_back(m_cnt);
        if (rst) begin
            m_cnt    = '0;
            m_active = MASK;
            m_pend   = '0;
            m_wbv    = '0;
            exp_q.delete();
        end else begin
            if (!halt) m_cnt = (m_cnt == IDW'(NH - 1)) ? '0 : m_cnt + 1'b1;
            n_active = m_active;
            n_pend   = m_pend;
            // A sleep request is honoured only when no wake is present for that hart.
            if (sv && !wk[sh] && m_active[sh]) begin
`ifdef HART_SLOT_SCHED_WAKE_PENDING_EN
                if (m_pend[sh]) n_pend[sh] = 1'b0;
                else            n_active[sh] = 1'b0;
`else
                n_active[sh] = 1'b0;
`endif
            end
            for (int h = 0; h < NH; h++) begin
                if (wk[h]) begin
                    if (!m_active[h]) n_active[h] = 1'b1;
`ifdef HART_SLOT_SCHED_WAKE_PENDING_EN
                    else if (!(sv && sh == IDW'(h))) n_pend[h] = 1'b1;
`endif
                end
            end
            m_active = n_active;
            m_pend   = n_pend;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        i_halt        = 1'b0;
        i_sleep_valid = 1'b0;
        i_sleep_hart  = '0;
        i_wake        = '0;
        @(posedge clk);
        #1;
        // Reset values
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        check("rst_wb_hart_id", 32'(o_wb_hart_id), 32'd0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);

        // Free-running rotation
        idle(10);

        // Sleep hart 2
        cycle(1'b0, 1'b1, 2'd2, '0, 1'b0);
        check("sleep2_active", 32'(o_hart_active), 32'b1011);
        idle(8);

        // Wake hart 2
        cycle(1'b0, 1'b0, '0, 4'b0100, 1'b0);
        check("wake2_active", 32'(o_hart_active), 32'b1111);
        idle(6);

        // Sleep and wake for hart 1 in the same cycle: the wake wins
        cycle(1'b0, 1'b1, 2'd1, 4'b0010, 1'b0);
        check("wake_wins_active", 32'(o_hart_active), 32'b1111);
        idle(6);

        // Wake hart 3 while it runs, then sleep it 5 cycles later
        cycle(1'b0, 1'b0, '0, 4'b1000, 1'b0);
        idle(4);
        cycle(1'b0, 1'b1, 2'd3, '0, 1'b0);
`ifdef HART_SLOT_SCHED_WAKE_PENDING_EN
        check("pending_sleep3", 32'(o_hart_active), 32'b1111);
`else
        check("pending_sleep3", 32'(o_hart_active), 32'b0111);
`endif
        idle(2);
        cycle(1'b0, 1'b1, 2'd3, '0, 1'b0);
        check("second_sleep3", 32'(o_hart_active), 32'b0111);
        idle(3);
        cycle(1'b0, 1'b0, '0, 4'b1000, 1'b0);
        idle(2);

        // Halt at slot 1, then reset mid-run
        for (int i = 0; i < 8 && m_cnt != 2'd1; i++) idle(1);
        check("halt_start_cnt", 32'(o_hart_id), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, '0, 1'b0);
        idle(2);
        cycle(1'b0, 1'b1, 2'd0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        check("midrst_hart_id", 32'(o_hart_id), 32'd0);
        check("midrst_wb_valid", 32'(o_wb_valid), 32'd0);
        check("midrst_active", 32'(o_hart_active), 32'b1111);
        idle(6);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0),
                  IDW'($urandom_range(0, NH - 1)),
                  ($urandom_range(0, 4) == 0) ? NH'($urandom_range(0, 15)) : '0,
                  ($urandom_range(0, 63) == 0));
        end
        idle(D + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
